// File: rtl/ov5640_cfg_seq_if.sv
// Bus between the configuration sequencer (master) and the serial register-write engine (slave).
interface ov5640_cfg_seq_if;
  logic [31:0] i2c_data;
  logic        start;
  logic        tr_end;
  logic        ack;

  modport master (output i2c_data, output start, input tr_end, input ack);
  modport slave  (input i2c_data, input start, output tr_end, output ack);
endinterface

// File: rtl/ov5640_cfg_seq.sv
// OV5640 register-table sequencer: waits out power-up, then writes each LUT entry with NACK retries.
// Optional transfer watchdog is compiled in with `define CFG_TIMEOUT_EN.
module ov5640_cfg_seq #(
  parameter logic [7:0] DEV_ADDR    = 8'h78,
  parameter int         LUT_SIZE    = 252,
  parameter int         POWERUP_CYC = 20000,
  parameter int         GAP_CYC     = 4,
  parameter int         MAX_RETRY   = 3,
  parameter int         TIMEOUT_CYC = 64
) (
  input  logic                   clock_i2c,
  input  logic                   camera_rstn,
  input  logic                   cfg_restart_i,
  output logic [9:0]             lut_index_o,
  input  logic [23:0]            lut_data_i,
  ov5640_cfg_seq_if.master       eng,
  output logic                   reg_conf_done_o,
  output logic                   cfg_err_o,
  output logic [9:0]             err_index_o
);

  localparam logic [2:0] PWRUP = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] XFER  = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] FAIL  = 3'd6;

  localparam int PW_W  = $clog2(POWERUP_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC);

  logic [2:0]       state_q, state_d;
  logic [9:0]       idx_q, idx_d;
  logic [31:0]      data_q, data_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [9:0]       err_idx_q, err_idx_d;
  logic [PW_W-1:0]  pwr_q, pwr_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [3:0]       retry_q, retry_d;
  logic             retry_pend_q, retry_pend_d;
  logic             ack_q, ack_d;
`ifdef CFG_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0]  wd_q, wd_d;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    data_d       = data_q;
    start_d      = start_q;
    done_d       = done_q;
    err_d        = err_q;
    err_idx_d    = err_idx_q;
    pwr_d        = pwr_q;
    gap_d        = gap_q;
    retry_d      = retry_q;
    retry_pend_d = retry_pend_q;
    ack_d        = ack_q;
`ifdef CFG_TIMEOUT_EN
    wd_d         = wd_q;
`endif
    case (state_q)
      PWRUP: begin
        start_d = 1'b0;
        if (pwr_q == PW_W'(POWERUP_CYC)) state_d = LOAD;
        else                             pwr_d   = pwr_q + 1'b1;
      end
      LOAD: begin
        data_d = {DEV_ADDR, lut_data_i};
        // A retry reloads the same entry but keeps counting attempts.
        if (!retry_pend_q) retry_d = 4'd0;
        retry_pend_d = 1'b0;
        start_d      = 1'b1;
        state_d      = XFER;
`ifdef CFG_TIMEOUT_EN
        wd_d = '0;
`endif
      end
      XFER: begin
        if (eng.tr_end) begin
          ack_d   = eng.ack;
          start_d = 1'b0;
          state_d = CHECK;
        end
`ifdef CFG_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          ack_d   = 1'b1;
          start_d = 1'b0;
          state_d = CHECK;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      CHECK: begin
        if (!ack_q) begin
          if (idx_q == 10'(LUT_SIZE - 1)) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 10'd1;
            gap_d   = '0;
            state_d = GAP;
          end
        end else if (retry_q < 4'(MAX_RETRY)) begin
          retry_d      = retry_q + 4'd1;
          retry_pend_d = 1'b1;
          gap_d        = '0;
          state_d      = GAP;
        end else begin
          err_d     = 1'b1;
          err_idx_d = idx_q;
          state_d   = FAIL;
        end
      end
      GAP: begin
        start_d = 1'b0;
        if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = LOAD;
        else                              gap_d   = gap_q + 1'b1;
      end
      DONE, FAIL: start_d = 1'b0;
      default:    state_d = PWRUP;
    endcase

    // Restart overrides whatever the state logic decided this cycle.
    if (cfg_restart_i) begin
      done_d       = 1'b0;
      err_d        = 1'b0;
      err_idx_d    = 10'd0;
      idx_d        = 10'd0;
      retry_d      = 4'd0;
      retry_pend_d = 1'b0;
      start_d      = 1'b0;
      gap_d        = '0;
      state_d      = GAP;
    end
  end

  always_ff @(posedge clock_i2c) begin
    if (!camera_rstn) begin
      state_q      <= PWRUP;
      idx_q        <= 10'd0;
      data_q       <= 32'd0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_idx_q    <= 10'd0;
      pwr_q        <= '0;
      gap_q        <= '0;
      retry_q      <= 4'd0;
      retry_pend_q <= 1'b0;
      ack_q        <= 1'b0;
`ifdef CFG_TIMEOUT_EN
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      start_q      <= start_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_idx_q    <= err_idx_d;
      pwr_q        <= pwr_d;
      gap_q        <= gap_d;
      retry_q      <= retry_d;
      retry_pend_q <= retry_pend_d;
      ack_q        <= ack_d;
`ifdef CFG_TIMEOUT_EN
      wd_q         <= wd_d;
`endif
    end
  end

  assign lut_index_o     = idx_q;
  assign eng.i2c_data    = data_q;
  assign eng.start       = start_q;
  assign reg_conf_done_o = done_q;
  assign cfg_err_o       = err_q;
  assign err_index_o     = err_idx_q;

endmodule

// File: doc/ov5640_cfg_seq.md
Name: ov5640_cfg_seq

Overview:
- Sequencer that drives the camera's serial register-write engine, one 32-bit frame per entry (`i2c_data`, `start`, `tr_end`, `ack`).
- Walks an external register lookup table after power-up, one entry per write transfer.
- Retries NACKed writes, then reports `reg_conf_done` or `cfg_err` to the camera pipeline.
- Sits between the camera reset/power logic and the write engine, in the `clock_i2c` domain.

Parameters:
- `DEV_ADDR`, 8'h78, 8-bit write address of the camera, sent as `i2c_data[31:24]`.
- `LUT_SIZE`, 252, number of table entries to write; legal range 1..1023.
- `POWERUP_CYC`, 20000, `clock_i2c` cycles to wait after reset before the first write (1 s at 20 kHz); minimum 1.
- `GAP_CYC`, 4, cycles `start` is held low between transfers; minimum 2.
- `MAX_RETRY`, 3, extra attempts per entry after a NACK; range 0..15.
- `TIMEOUT_CYC`, 64, transfer watchdog limit; used only with `CFG_TIMEOUT_EN`.

Ports:
- `clock_i2c` in 1: sequencer clock, same clock as the write engine.
- `camera_rstn` in 1: reset, active-low.
- `cfg_restart` in 1: one-cycle pulse; re-runs the whole table from entry 0 with no power-up wait.
- `lut_index` out 10: table entry being written.
- `lut_data` in 24: table word for `lut_index`; [23:8] register address, [7:0] value; combinational from `lut_index`.
- `i2c_data` out 32: frame for the engine, {`DEV_ADDR`, `lut_data`}.
- `start` out 1: transfer request to the engine, held high for the whole transfer.
- `tr_end` in 1: engine transfer-complete flag; stays high while `start` is high.
- `ack` in 1: engine OR'd acknowledge; 0 = all bytes ACKed; valid while `tr_end`=1.
- `reg_conf_done` out 1: table completely written with no errors; sticky.
- `cfg_err` out 1: an entry failed after all retries; sticky.
- `err_index` out 10: `lut_index` of the failing entry.

Behaviour:
- Reset is synchronous and active-low: `camera_rstn` is sampled on the rising edge of `clock_i2c`.
- Reset values: state=PWRUP, `lut_index`=0, `start`=0, `i2c_data`=0, `reg_conf_done`=0, `cfg_err`=0, `err_index`=0, counters=0.
- Reset mid-transfer drops `start` on that edge. This aborts the engine, which re-arms on its own when `start` is low.
- PWRUP: count `POWERUP_CYC` cycles with `start`=0, then go to LOAD.
- LOAD (1 cycle): register `i2c_data` <= {`DEV_ADDR`, `lut_data`}; clear the retry counter only when entering from a new index; go to XFER.
  - `i2c_data` stays stable from LOAD until the next LOAD.
- XFER: `start`=1.
  - On the first cycle with `tr_end`=1, sample `ack`, then set `start`=0 on the next edge and go to CHECK.
- CHECK (1 cycle) when `ack`=0:
  - If `lut_index`=`LUT_SIZE`-1, go to DONE.
  - Otherwise `lut_index`++ and go to GAP.
- CHECK when `ack`=1:
  - If retries < `MAX_RETRY`: retries++, keep `lut_index`, go to GAP. The same entry is reloaded.
  - Otherwise `cfg_err`<=1, `err_index`<=`lut_index`, go to FAIL.
- GAP: hold `start`=0 for `GAP_CYC` cycles, then go to LOAD. This guarantees the engine clears `tr_end` before the next transfer.
- DONE: `reg_conf_done`<=1, `start`=0; stay until reset or `cfg_restart`.
- FAIL: `start`=0, table stops; stay until reset or `cfg_restart`.
- `cfg_restart` is accepted in any state:
  - Clears `reg_conf_done`, `cfg_err`, `err_index`, `lut_index` and the retry counter.
  - Sets `start`=0, then goes to GAP, so there is at least a `GAP_CYC` low period before LOAD.
  - Wins over any same-cycle `tr_end` or CHECK decision.
- `reg_conf_done` and `cfg_err` are never both 1.
- Counters:
  - The power-up counter is wide enough for `POWERUP_CYC` and saturates.
  - The gap counter resets on each GAP entry.
- Throughput: each entry takes the engine's transfer time + `GAP_CYC` + 3 cycles.
- `LUT_SIZE`=1: a single entry is written, then DONE.
- `lut_index` never exceeds `LUT_SIZE`-1.

Optional Feature:
- Macro `CFG_TIMEOUT_EN`.
- Defined: a watchdog counts XFER cycles.
  - Reaching `TIMEOUT_CYC` without `tr_end` is treated as `ack`=1: `start` drops and CHECK runs with the normal retry and fail rules.
  - The watchdog clears on every XFER entry.
- Not defined: no watchdog and no counter logic; XFER waits on `tr_end` forever.

Test Plan:
- `LUT_SIZE`=3, `POWERUP_CYC`=8, engine model always `ack`=0 -> first `start` rises 10 cycles after reset release.
  - `i2c_data`=0x78_aaaa_dd for entries 0,1,2; `start` is low ≥4 cycles between transfers; `reg_conf_done`=1 after entry 2; `cfg_err`=0.
- Engine NACKs entry 1 twice, then ACKs (`MAX_RETRY`=3) -> entry 1 is sent 3 times with identical `i2c_data`, then entry 2; `reg_conf_done`=1.
- Engine NACKs entry 1 always -> 4 attempts, then `cfg_err`=1, `err_index`=1, `start` stays 0, entry 2 is never sent.
- Reset asserted during the entry-1 transfer -> `start`=0 on the next edge; after release, PWRUP restarts and entry 0 is rewritten.
- `cfg_restart` pulse in DONE, and again in FAIL -> flags clear; sequence rewrites from entry 0 after a 4-cycle gap, with no power-up wait.
- `CFG_TIMEOUT_EN` defined, `TIMEOUT_CYC`=64, engine never raises `tr_end` -> `start` drops after 64 XFER cycles.
  - 4 attempts, then `cfg_err`=1, `err_index`=0.
